// File: rtl/deoxys_constants_if.sv
// Handshake bundle between the Deoxys-BC round-constant generator and the
// tweakey/round datapath.
//   start, dir : sequence request and direction (0 = forward, 1 = reverse)
//   ready      : consumer accepts the current beat
//   valid      : a constant beat is on 'constant'
//   constant   : RNDS_PER_CLK lanes; lane i sits at bits [8i+7:8i]
//   last       : current beat is the final one of the sequence
//   busy       : generator is not idle
//   done       : one-cycle pulse after the final beat has been accepted
// master = datapath/controller side, slave = generator side.
interface deoxys_constants_if #(
    parameter int RNDS_PER_CLK = 1
) ();
    logic                      start;
    logic                      dir;
    logic                      ready;
    logic                      valid;
    logic [8*RNDS_PER_CLK-1:0] constant;
    logic                      last;
    logic                      busy;
    logic                      done;

    modport master (
        output start, dir, ready,
        input  valid, constant, last, busy, done
    );

    modport slave (
        input  start, dir, ready,
        output valid, constant, last, busy, done
    );
endinterface

// File: rtl/deoxys_constants_gen.sv
// Deoxys-BC round-constant generator. Constants come from a GF(2^8) xtime
// LFSR (poly 0x11B, seed 0x2F). Forward runs emit indices 0..NUM_RNDS;
// reverse runs first wind the LFSR up to index NUM_RNDS and then walk it
// back with the inverse step, so decryption sees last round first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cif        : deoxys_constants_if.slave (start/dir/ready in,
//                valid/constant/last/busy/done out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; base holds the seed
// WIND  | stepping base forward NUM_RNDS times ahead of a reverse run
// RUN   | presenting beats; base advances on each accepted beat
// DONE  | one-cycle done pulse, base reseeded
module deoxys_constants_gen #(
    parameter int NUM_RNDS     = 16,
    parameter int RNDS_PER_CLK = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    deoxys_constants_if.slave   cif
);
    localparam logic [7:0] SEED   = 8'h2F;
    localparam int         BEATS  = (NUM_RNDS + RNDS_PER_CLK) / RNDS_PER_CLK;
    localparam int         CNT_W  = $clog2(NUM_RNDS + 2);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] WIND_LAST = CNT_W'((NUM_RNDS > 0) ? NUM_RNDS - 1 : 0);

    typedef enum logic [1:0] {IDLE, WIND, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;

    logic [7:0]                lane_val [0:RNDS_PER_CLK];
    logic [8*RNDS_PER_CLK-1:0] const_out;

    function automatic logic [7:0] step_fwd(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] step_rev(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1B) >> 1) | 8'h80) : (x >> 1);
    endfunction

    // Unrolled step chain; the extra element is the base for the next beat.
    always_comb begin
        lane_val[0] = base_q;
        for (int i = 1; i <= RNDS_PER_CLK; i++) begin
            lane_val[i] = dir_q ? step_rev(lane_val[i-1]) : step_fwd(lane_val[i-1]);
        end
    end

    // Lanes past the end of the sequence (final partial beat) read as zero.
    // The offset from the starting index is the same in both directions.
    always_comb begin
        const_out = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < RNDS_PER_CLK; i++) begin
                if (int'(cnt_q) * RNDS_PER_CLK + i <= NUM_RNDS) begin
                    const_out[8*i +: 8] = lane_val[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (cif.start) begin
                    dir_d   = cif.dir;
                    base_d  = SEED;
                    cnt_d   = '0;
                    state_d = (cif.dir && NUM_RNDS > 0) ? WIND : RUN;
                end
            end
            WIND: begin
                base_d = step_fwd(base_q);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == WIND_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cif.ready) begin
                    base_d = lane_val[RNDS_PER_CLK];
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == BEAT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                base_d  = SEED;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= SEED;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign cif.valid    = (state_q == RUN);
    assign cif.last     = (state_q == RUN) && (cnt_q == BEAT_LAST);
    assign cif.busy     = (state_q != IDLE);
    assign cif.done     = (state_q == DONE);
    assign cif.constant = const_out;
endmodule

// File: tb/tb_deoxys_constants_gen.sv
module tb_deoxys_constants_gen;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    deoxys_constants_if #(.RNDS_PER_CLK(1)) if1 ();
    deoxys_constants_if #(.RNDS_PER_CLK(4)) if4 ();

    deoxys_constants_gen #(.NUM_RNDS(N), .RNDS_PER_CLK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cif(if1.slave)
    );
    deoxys_constants_gen #(.NUM_RNDS(N), .RNDS_PER_CLK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cif(if4.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  cst [0:N];
    logic [31:0] got [0:31];

    // Reference: constant index j is 0x2F multiplied by x^j in GF(2^8) mod 0x11B.
    task automatic build_model();
        int x;
        x = 'h2F;
        for (int j = 0; j <= N; j++) begin
            cst[j] = 8'(x);
            x = x * 2;
            if (x >= 256) x = x ^ 'h11B;
        end
    endtask

    function automatic logic [31:0] exp_beat(input int r, input bit d, input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < r; i++) begin
            int idx;
            idx = d ? (N - k * r - i) : (k * r + i);
            if (idx >= 0 && idx <= N) v[8*i +: 8] = cst[idx];
        end
        return v;
    endfunction

    function automatic bit o_valid(input bit w); return w ? if4.valid : if1.valid; endfunction
    function automatic bit o_last(input bit w);  return w ? if4.last  : if1.last;  endfunction
    function automatic bit o_busy(input bit w);  return w ? if4.busy  : if1.busy;  endfunction
    function automatic bit o_done(input bit w);  return w ? if4.done  : if1.done;  endfunction
    function automatic logic [31:0] o_const(input bit w);
        return w ? if4.constant : {24'h0, if1.constant};
    endfunction

    task automatic set_in(input bit w, input bit s, input bit d, input bit r);
        if (w) begin
            if4.start = s; if4.dir = d; if4.ready = r;
        end else begin
            if1.start = s; if1.dir = d; if1.ready = r;
        end
    endtask

    // Runs one full sequence on DUT w (0: 1 lane, 1: 4 lanes), checking every
    // cycle against the model. Optional fixed stall, stray start and a start
    // poked into the DONE cycle.
    task automatic run_seq(input bit w, input bit d, input int rdy_pct,
                           input int stall_beat, input int stall_len,
                           input int mid_start, input bit poke_done);
        int r, nb, k, cyc, lat, stall_left;
        bit rdy, poke;
        r = w ? 4 : 1;
        nb = (N + r) / r;
        k = 0; cyc = 0; stall_left = stall_len;
        @(negedge clk); set_in(w, 1'b1, d, 1'b0);
        @(negedge clk); set_in(w, 1'b0, !d, 1'b0);
        lat = 1;
        while (!o_valid(w) && lat < 200) begin
            @(negedge clk); lat++;
        end
        checks++;
        if (lat != (d ? N + 1 : 1))
            begin errors++; $display("FAIL latency w=%0d d=%0d got %0d want %0d", w, d, lat, d ? N + 1 : 1); end
        checks++;
        if (o_busy(w) !== 1'b1)
            begin errors++; $display("FAIL busy_run got %0b want 1", o_busy(w)); end
        while (k < nb && cyc < 2000) begin
            checks++;
            if (o_valid(w) !== 1'b1 || o_const(w) !== exp_beat(r, d, k))
                begin errors++; $display("FAIL beat w=%0d d=%0d k=%0d got v=%0b %h want v=1 %h", w, d, k, o_valid(w), o_const(w), exp_beat(r, d, k)); end
            checks++;
            if (o_last(w) !== (k == nb - 1))
                begin errors++; $display("FAIL last k=%0d got %0b want %0b", k, o_last(w), k == nb - 1); end
            if (k == stall_beat && stall_left > 0) begin
                rdy = 1'b0; stall_left--;
            end else begin
                rdy = ($urandom_range(0, 99) < rdy_pct);
            end
            poke = (k == mid_start);
            set_in(w, poke, 1'b1, rdy);
            if (rdy) begin got[k] = o_const(w); k++; end
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc >= 2000) begin errors++; $display("FAIL timeout w=%0d got beats %0d want %0d", w, k, nb); end
        set_in(w, poke_done, 1'b0, 1'b0);
        checks++;
        if (o_done(w) !== 1'b1 || o_valid(w) !== 1'b0 || o_busy(w) !== 1'b1)
            begin errors++; $display("FAIL done_pulse got d=%0b v=%0b b=%0b want 1 0 1", o_done(w), o_valid(w), o_busy(w)); end
        @(negedge clk);
        set_in(w, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_done(w) !== 1'b0 || o_busy(w) !== 1'b0 || o_valid(w) !== 1'b0 || o_const(w) !== 32'h0)
            begin errors++; $display("FAIL idle_after got d=%0b b=%0b v=%0b c=%h want 0 0 0 0", o_done(w), o_busy(w), o_valid(w), o_const(w)); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (o_valid(w[0]) !== 1'b0 || o_last(w[0]) !== 1'b0 || o_busy(w[0]) !== 1'b0 ||
                o_done(w[0]) !== 1'b0 || o_const(w[0]) !== 32'h0)
                begin errors++; $display("FAIL reset w=%0d got v=%0b l=%0b b=%0b d=%0b c=%h want all 0", w, o_valid(w[0]), o_last(w[0]), o_busy(w[0]), o_done(w[0]), o_const(w[0])); end
        end
    endtask

    task automatic test_forward();
        run_seq(1'b0, 1'b0, 100, -1, 0, -1, 1'b0);
        checks++;
        if (got[0] !== 32'h2F || got[3] !== 32'h63 || got[16] !== 32'h72)
            begin errors++; $display("FAIL fwd_vectors got %h %h %h want 2f 63 72", got[0], got[3], got[16]); end
    endtask

    task automatic test_reverse();
        run_seq(1'b0, 1'b1, 100, -1, 0, -1, 1'b0);
        checks++;
        if (got[0] !== 32'h72 || got[1] !== 32'h39 || got[16] !== 32'h2F)
            begin errors++; $display("FAIL rev_vectors got %h %h %h want 72 39 2f", got[0], got[1], got[16]); end
    endtask

    task automatic test_backpressure();
        run_seq(1'b0, 1'b0, 100, 3, 5, -1, 1'b0);
        checks++;
        if (got[3] !== 32'h63 || got[4] !== 32'hC6)
            begin errors++; $display("FAIL stall_vectors got %h %h want 63 c6", got[3], got[4]); end
    endtask

    task automatic test_wide();
        run_seq(1'b1, 1'b0, 100, -1, 0, -1, 1'b0);
        checks++;
        if (got[0] !== 32'h63BC5E2F || got[1] !== 32'h6A3597C6 || got[4] !== 32'h00000072)
            begin errors++; $display("FAIL wide_fwd got %h %h %h want 63bc5e2f 6a3597c6 00000072", got[0], got[1], got[4]); end
        run_seq(1'b1, 1'b1, 100, -1, 0, -1, 1'b0);
        checks++;
        if (got[0] !== 32'hC5913972 || got[4] !== 32'h0000002F)
            begin errors++; $display("FAIL wide_rev got %h %h want c5913972 0000002f", got[0], got[4]); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(30, 100), -1, 0, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); set_in(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk); set_in(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if (if1.constant !== cst[8] || if1.valid !== 1'b1)
            begin errors++; $display("FAIL pre_reset_beat got %h want %h", if1.constant, cst[8]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if1.valid !== 1'b0 || if1.busy !== 1'b0 || if1.done !== 1'b0 ||
            if1.last !== 1'b0 || if1.constant !== 8'h00)
            begin errors++; $display("FAIL async_reset got v=%0b b=%0b d=%0b l=%0b c=%h want all 0", if1.valid, if1.busy, if1.done, if1.last, if1.constant); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (if1.busy !== 1'b0 || if1.valid !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle got b=%0b v=%0b want 0 0", if1.busy, if1.valid); end
        run_seq(1'b0, 1'b0, 100, -1, 0, -1, 1'b0);
        checks++;
        if (got[0] !== 32'h2F)
            begin errors++; $display("FAIL restart_first got %h want 2f", got[0]); end
    endtask

    task automatic test_start_ignored();
        // Stray reverse start mid-run and a start during DONE are both ignored.
        run_seq(1'b0, 1'b0, 100, -1, 0, 5, 1'b1);
        run_seq(1'b0, 1'b1, 100, -1, 0, -1, 1'b0);
        checks++;
        if (got[0] !== 32'h72)
            begin errors++; $display("FAIL rev_after_ignored got %h want 72", got[0]); end
    endtask

    initial begin
        build_model();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_forward();
        test_reverse();
        test_backpressure();
        test_wide();
        test_random();
        test_reset_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
